// File: rtl/univ_reg_sync.sv
// Universal WIDTH-bit register: clear/set, hold/load/shift/rotate, optional inc/dec (UNIV_REG_COUNT_EN).
// Latency: one clk edge from sampled inputs to q/carry; zero is combinational from current q.
// Backpressure: none; en low holds q and carry while reset/clear/set still act.
module univ_reg_sync #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_nxt;
  logic             carry_nxt;

  // Next value in priority order: reset > clear > set > mode op (when en) > hold.
  always_comb begin
    q_nxt     = q;
    carry_nxt = carry;
    if (reset) begin
      q_nxt     = RESET_VAL;
      carry_nxt = 1'b0;
    end else if (clear) begin
      q_nxt     = '0;
      carry_nxt = 1'b0;
    end else if (set) begin
      q_nxt     = '1;
      carry_nxt = 1'b0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_LOAD: begin
          q_nxt     = d;
          carry_nxt = 1'b0;
        end
        MODE_SHL: begin
          q_nxt     = {q[WIDTH-2:0], sin_lsb};
          carry_nxt = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_nxt     = {sin_msb, q[WIDTH-1:1]};
          carry_nxt = q[0];
        end
        MODE_ROL: begin
          q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
          carry_nxt = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_nxt     = {q[0], q[WIDTH-1:1]};
          carry_nxt = q[0];
        end
`ifdef UNIV_REG_COUNT_EN
        // Carry flags the wrap: all-ones going up, zero going down.
        MODE_INC: begin
          q_nxt     = q + 1'b1;
          carry_nxt = &q;
        end
        MODE_DEC: begin
          q_nxt     = q - 1'b1;
          carry_nxt = ~|q;
        end
`endif
        // Hold, and inc/dec when counting is not built in.
        default: begin
          q_nxt     = q;
          carry_nxt = carry;
        end
      endcase
    end
  end

  // State register; all changes happen on the rising edge.
  always_ff @(posedge clk) begin
    q     <= q_nxt;
    carry <= carry_nxt;
  end

  // Zero flag reflects the register as it stands now.
  always_comb begin
    zero = (q == '0);
  end

endmodule

// File: tb/tb_univ_reg_sync.sv
// Bench for univ_reg_sync: two instances (RESET_VAL 0x00 and 0x5A) share stimulus.
// An arithmetic model tracks both and is compared every negedge; literal checks pin key steps.
// Build with or without UNIV_REG_COUNT_EN; expectations follow the same macro.
module tb_univ_reg_sync;

  logic       clk = 1'b0;
  logic       reset, clear, set, en, sin_lsb, sin_msb;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q0, q1;
  logic       carry0, carry1, zero0, zero1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state for both instances.
  int m_q0, m_c0, m_q1, m_c1;

  always #5 clk = ~clk;

  univ_reg_sync #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .set(set), .en(en), .mode(mode),
    .d(d), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q0), .carry(carry0), .zero(zero0)
  );

  univ_reg_sync #(.WIDTH(8), .RESET_VAL(8'h5A)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .set(set), .en(en), .mode(mode),
    .d(d), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q1), .carry(carry1), .zero(zero1)
  );

  // Next {carry, q} from the operation rules, as plain integer arithmetic.
  function automatic void model_next(input int q, input int c, input int rv,
                                     output int nq, output int nc);
    nq = q;
    nc = c;
    if (reset)      begin nq = rv;  nc = 0; end
    else if (clear) begin nq = 0;   nc = 0; end
    else if (set)   begin nq = 255; nc = 0; end
    else if (en) begin
      case (int'(mode))
        1: begin nq = int'(d); nc = 0; end
        2: begin nq = (q * 2 + int'(sin_lsb)) % 256; nc = q / 128; end
        3: begin nq = q / 2 + int'(sin_msb) * 128;   nc = q % 2;   end
        4: begin nq = (q * 2) % 256 + q / 128;       nc = q / 128; end
        5: begin nq = q / 2 + (q % 2) * 128;         nc = q % 2;   end
`ifdef UNIV_REG_COUNT_EN
        6: begin nq = (q + 1) % 256;   nc = (q == 255) ? 1 : 0; end
        7: begin nq = (q + 255) % 256; nc = (q == 0) ? 1 : 0;   end
`endif
        default: ;
      endcase
    end
  endfunction

  // Advance the model on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    int a, b;
    model_next(m_q0, m_c0, 8'h00, a, b);
    m_q0 <= a; m_c0 <= b;
    model_next(m_q1, m_c1, 8'h5A, a, b);
    m_q1 <= a; m_c1 <= b;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model q0",     int'(q0),     m_q0);
      chk("model carry0", int'(carry0), m_c0);
      chk("model zero0",  int'(zero0),  (m_q0 == 0) ? 1 : 0);
      chk("model q1",     int'(q1),     m_q1);
      chk("model carry1", int'(carry1), m_c1);
      chk("model zero1",  int'(zero1),  (m_q1 == 0) ? 1 : 0);
    end
  end

  // Drive one set of inputs, let one edge pass, return just after it.
  task automatic step(input logic r, input logic c, input logic s, input logic e,
                      input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sm);
    reset = r; clear = c; set = s; en = e; mode = m; d = dd; sin_lsb = sl; sin_msb = sm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; set = 1'b0; en = 1'b0;
    mode = 3'd0; d = 8'h00; sin_lsb = 1'b0; sin_msb = 1'b0;
    #2;

    // Reset state.
    step(1, 0, 0, 0, 3'd0, 8'h00, 0, 0);
    chk_en = 1'b1;
    chk("reset q0", int'(q0), 8'h00);
    chk("reset carry0", int'(carry0), 0);
    chk("reset zero0", int'(zero0), 1);
    chk("reset q1", int'(q1), 8'h5A);
    chk("reset zero1", int'(zero1), 0);

    // Parallel load.
    step(0, 0, 0, 1, 3'b001, 8'hA5, 0, 0);
    chk("load q", int'(q0), 8'hA5);
    chk("load carry", int'(carry0), 0);
    chk("load zero", int'(zero0), 0);

    // Shift left then shift right.
    step(0, 0, 0, 1, 3'b001, 8'h81, 0, 0);
    step(0, 0, 0, 1, 3'b010, 8'h00, 1, 0);
    chk("shl q", int'(q0), 8'h03);
    chk("shl carry", int'(carry0), 1);
    step(0, 0, 0, 1, 3'b011, 8'h00, 0, 0);
    chk("shr q", int'(q0), 8'h01);
    chk("shr carry", int'(carry0), 1);

    // Rotate right then rotate left.
    step(0, 0, 0, 1, 3'b001, 8'h81, 0, 0);
    step(0, 0, 0, 1, 3'b101, 8'h00, 0, 0);
    chk("ror q", int'(q0), 8'hC0);
    chk("ror carry", int'(carry0), 1);
    step(0, 0, 0, 1, 3'b100, 8'h00, 0, 0);
    chk("rol q", int'(q0), 8'h81);
    chk("rol carry", int'(carry0), 1);

    // Increment / decrement wrap (hold when counting is not built in).
    step(0, 0, 0, 1, 3'b001, 8'hFF, 0, 0);
    step(0, 0, 0, 1, 3'b110, 8'h00, 0, 0);
`ifdef UNIV_REG_COUNT_EN
    chk("inc q", int'(q0), 8'h00);
    chk("inc carry", int'(carry0), 1);
    chk("inc zero", int'(zero0), 1);
`else
    chk("inc-hold q", int'(q0), 8'hFF);
    chk("inc-hold carry", int'(carry0), 0);
`endif
    step(0, 0, 0, 1, 3'b111, 8'h00, 0, 0);
`ifdef UNIV_REG_COUNT_EN
    chk("dec q", int'(q0), 8'hFF);
    chk("dec carry", int'(carry0), 1);
`else
    chk("dec-hold q", int'(q0), 8'hFF);
    chk("dec-hold carry", int'(carry0), 0);
`endif
    // Decrement from zero (or hold) and increment from mid-range.
    step(0, 0, 0, 1, 3'b001, 8'h00, 0, 0);
    step(0, 0, 0, 1, 3'b111, 8'h00, 0, 0);
    step(0, 0, 0, 1, 3'b001, 8'h7F, 0, 0);
    step(0, 0, 0, 1, 3'b110, 8'h00, 0, 0);

    // Priority: clear beats set and load; set acts with en low; reset beats clear.
    step(0, 0, 0, 1, 3'b001, 8'h3C, 0, 0);
    step(0, 1, 1, 1, 3'b001, 8'h55, 0, 0);
    chk("clear>set q", int'(q0), 8'h00);
    step(0, 0, 1, 0, 3'b001, 8'h55, 0, 0);
    chk("set en=0 q", int'(q1), 8'hFF);
    step(1, 1, 0, 1, 3'b001, 8'h55, 0, 0);
    chk("reset>clear q1", int'(q1), 8'h5A);
    chk("reset>clear q0", int'(q0), 8'h00);

    // en low with shift mode: three edges of hold.
    step(0, 0, 0, 1, 3'b001, 8'h81, 0, 0);
    step(0, 0, 0, 1, 3'b010, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 3'b010, 8'h00, 1, 1);
      chk("en=0 q", int'(q0), 8'h02);
      chk("en=0 carry", int'(carry0), 1);
    end

    // Reset in the middle of a shift run; next op starts from RESET_VAL.
    step(0, 0, 0, 1, 3'b001, 8'hF0, 0, 0);
    step(0, 0, 0, 1, 3'b011, 8'h00, 0, 1);
    step(1, 0, 0, 1, 3'b011, 8'h00, 0, 1);
    step(0, 0, 0, 1, 3'b011, 8'h00, 0, 1);
    chk("post-reset shr q1", int'(q1), 8'hAD);
    chk("post-reset shr carry1", int'(carry1), 0);
    chk("post-reset shr q0", int'(q0), 8'h80);

    // A short mixed run for the model comparison.
    step(0, 0, 0, 1, 3'b100, 8'h00, 0, 0);
    step(0, 0, 0, 1, 3'b101, 8'h00, 0, 0);
    step(0, 0, 0, 1, 3'b010, 8'h00, 1, 0);
    step(0, 0, 0, 1, 3'b000, 8'hEE, 1, 1);
    step(0, 0, 0, 1, 3'b110, 8'h00, 0, 0);
    step(0, 0, 0, 1, 3'b011, 8'h00, 1, 1);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_reg_sync.md
# univ_reg_sync

WIDTH-bit universal register: synchronous reset, clear and set, plus a mode-selected datapath for hold, parallel load, shift, rotate and optional increment/decrement. Generalises the single-bit sync set/reset flip-flop to a full register, adding serial I/O and a registered carry flag. Used as the general-purpose register and shifter element in the CPU datapath, e.g. the accumulator and shift unit.

## Interface

- WIDTH, 8, register width in bits; must be ≥ 2
- RESET_VAL, {WIDTH{1'b0}}, value loaded by `reset`

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; loads RESET_VAL, clears carry
- clear  in  1  synchronous clear to all zeros
- set  in  1  synchronous set to all ones
- en  in  1  mode enable; when low, the register holds (clear/set still act)
- mode  in  3  operation select (see Operation)
- d  in  WIDTH  parallel load data
- sin_lsb  in  1  serial bit entering at the LSB on shift-left
- sin_msb  in  1  serial bit entering at the MSB on shift-right
- q  out  WIDTH  register contents
- carry  out  1  registered flag: shifted-out bit or inc/dec wrap
- zero  out  1  combinational, high when q == 0

## Operation

- Per-edge priority: reset > clear > set > (en ? mode op : hold).
- reset: q ← RESET_VAL, carry ← 0.
- clear: q ← 0, carry ← 0. set: q ← all ones, carry ← 0.
- Modes, applied only when en=1 and no reset/clear/set:
  - 000 hold: q and carry unchanged
  - 001 load: q ← d, carry ← 0
  - 010 shift left: q ← {q[WIDTH-2:0], sin_lsb}, carry ← q[WIDTH-1]
  - 011 shift right: q ← {sin_msb, q[WIDTH-1:1]}, carry ← q[0]
  - 100 rotate left: q ← {q[WIDTH-2:0], q[WIDTH-1]}, carry ← q[WIDTH-1]
  - 101 rotate right: q ← {q[0], q[WIDTH-1:1]}, carry ← q[0]
  - 110 increment: q ← q+1 mod 2^WIDTH, carry ← (q was all ones)
  - 111 decrement: q ← q−1 mod 2^WIDTH, carry ← (q was 0)
- Arithmetic is unsigned, WIDTH bits, wraps silently; carry is the only overflow indication.
- en=0 is equivalent to mode 000; carry holds.
- zero is derived from the current q, not from the next value.

## Timing

- All updates take one cycle: a value applied before edge N appears on q/carry after edge N.
- Reset values: q = RESET_VAL, carry = 0, zero = (RESET_VAL == 0).
- Simultaneous clear and set: clear wins. Reset asserted together with anything: reset wins.
- Reset mid-sequence (e.g. during a run of shifts) aborts at that edge; the next op after deassertion starts from RESET_VAL.
- Mode, d and serial inputs are sampled only at the rising edge; there are no combinational paths from inputs to q or carry.

## Configuration

- UNIV_REG_COUNT_EN defined: modes 110/111 increment/decrement as above.
- Undefined: modes 110/111 behave exactly as hold (q and carry unchanged), and no adder/subtractor is synthesised. All other modes are identical in both builds.

## Test plan

- WIDTH=8: reset=1 for one edge → q=0x00, carry=0, zero=1; then load d=0xA5 → q=0xA5, carry=0, zero=0.
- q=0x81, shift left with sin_lsb=1 → q=0x03, carry=1; then shift right with sin_msb=0 → q=0x01, carry=1.
- q=0x81, rotate right → q=0xC0, carry=1; rotate left → q=0x81, carry=1.
- With UNIV_REG_COUNT_EN: q=0xFF, increment → q=0x00, carry=1, zero=1; decrement → q=0xFF, carry=1. Without the macro, the same stimulus leaves q=0xFF and carry unchanged.
- Priority check with q=0x3C: clear=1, set=1, mode=001, d=0x55 → q=0x00. Then set=1 with en=0 → q=0xFF. Then reset=1 with clear=1 and RESET_VAL=0x5A → q=0x5A.
- en=0 with mode=010 held for 3 edges → q and carry unchanged throughout.
